lsu_dmem: RTL

//  Parametrised load/store unit with a synchronous, byte-addressed, word-organised data memory, in the MEM stage.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_dmem_sram.sv | 29 ++
 rtl/lsu_dmem.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states,
// byte-enable generation and load-data extension.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_RESP} state_t;

  function automatic logic [3:0] be_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001;
      SZ_H:    m = 4'b0011;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m << addr_lo;
  endfunction

  function automatic logic [31:0] ld_extend(input logic [31:0] word, input logic [1:0] addr_lo,
                                            input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = {{24{b[7] & ~uns}}, b};
      SZ_H:    r = {{16{h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_dmem_sram.sv
// Single-port synchronous word RAM with per-byte write enables and registered read.
module dmem_sram #(
  parameter int DEPTH_WORDS = 16,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/lsu_dmem.sv
// MEM-stage load/store unit: request/response handshake, error checks, lane
// steering, post-reset zero sweep and a response hold register.
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DEPTH_WORDS    = 2**(ADDR_W-2),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-2:0] DEPTH_EXT = (ADDR_W-1)'(DEPTH_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH_WORDS - 1);

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic [1:0]       r_lo, r_size;
  logic             r_uns, r_load, fresh;
  logic [31:0]      hold, fmt;

  logic             accept, req_err;
  logic             ram_en, ram_we;
  logic [3:0]       ram_be;
  logic [IDX_W-1:0] ram_addr;
  logic [31:0]      ram_wdata, ram_rdata;

  always_comb begin
    req_ready = (state == ST_IDLE) || (state == ST_RESP && rsp_ready);
    accept    = req_valid && req_ready;
    req_err   = (req_size == 2'b11)
             || (req_size == SZ_H && req_addr[0])
             || (req_size == SZ_W && req_addr[1:0] != 2'b00)
             || ({1'b0, req_addr[ADDR_W-1:2]} >= DEPTH_EXT);
  end

  // The sweep owns the RAM port in CLEAR; otherwise only error-free accepts touch it.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state == ST_CLEAR) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_be   = '1;
      ram_addr = cnt;
    end else if (accept && !req_err) begin
      ram_en   = 1'b1;
      ram_we   = req_we;
      ram_be   = be_mask(req_size, req_addr[1:0]);
      ram_addr = req_addr[IDX_W+1:2];
      case (req_size)
        SZ_B:    ram_wdata = {4{req_wdata[7:0]}};
        SZ_H:    ram_wdata = {2{req_wdata[15:0]}};
        default: ram_wdata = req_wdata;
      endcase
    end
  end

  dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_sram (
    .clk   (clk),
    .en    (ram_en & ~rst),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Fresh RAM output is formatted directly in the first response cycle, then held.
  always_comb begin
    fmt       = r_load ? ld_extend(ram_rdata, r_lo, r_size, r_uns) : '0;
    rsp_rdata = !rsp_valid ? '0 : (fresh ? fmt : hold);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      init_done <= !CLEAR_ON_RESET;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      fresh     <= 1'b0;
      hold      <= '0;
      r_lo      <= '0;
      r_size    <= '0;
      r_uns     <= 1'b0;
      r_load    <= 1'b0;
    end else begin
      fresh <= accept;
      if (fresh) hold <= fmt;
      if (accept) begin
        r_lo    <= req_addr[1:0];
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_load  <= !req_we && !req_err;
        rsp_err <= req_err;
      end
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready && !accept) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
